// File: rtl/itcm_loader_pkg.sv
// Shared widths, frame constants, state encodings and error codes for the
// ITCM boot loader.
package itcm_loader_pkg;

    localparam int unsigned ITCM_RAM_AW = 10;
    localparam int unsigned ITCM_RAM_DW = 32;
    localparam int unsigned ITCM_RAM_MW = 4;

    localparam logic [7:0] LDR_SYNC = 8'hA5;

    localparam logic [2:0] LDR_IDLE   = 3'd0;
    localparam logic [2:0] LDR_HDR    = 3'd1;
    localparam logic [2:0] LDR_DATA   = 3'd2;
    localparam logic [2:0] LDR_CSUM   = 3'd3;
    localparam logic [2:0] LDR_VERIFY = 3'd4;

    localparam logic [1:0] LDR_ERR_RANGE  = 2'd1;
    localparam logic [1:0] LDR_ERR_CSUM   = 2'd2;
    localparam logic [1:0] LDR_ERR_VERIFY = 2'd3;

    // BASE must lie inside ITCM and BASE+N must not run past the end (33-bit sum).
    function automatic logic range_ok(input logic [31:0] base, input logic [15:0] n);
        logic [32:0] end_a;
        end_a = {1'b0, base} + {17'd0, n};
        return (base[31:ITCM_RAM_AW] == '0) && (end_a <= (33'd1 << ITCM_RAM_AW));
    endfunction

endpackage

// File: rtl/ldr_word_asm.sv
// Byte-to-word shifter: assembles four bytes little-endian and pulses
// word_valid_o, with the full word, on the cycle the 4th byte arrives.
module ldr_word_asm
    import itcm_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   byte_valid_i,
    input  logic [7:0]             byte_i,
    output logic                   word_valid_o,
    output logic [ITCM_RAM_DW-1:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sh_q, sh_d;

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (byte_valid_i) begin
            cnt_d = cnt_q + 2'd1;
            sh_d  = {byte_i, sh_q[23:8]};
        end
    end

    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
    assign word_o       = {byte_i, sh_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/itcm_loader.sv
// Boot-time ITCM loader: receives a framed byte stream, writes words into ITCM,
// checks the frame checksum, reads back to verify, and releases the core.
module itcm_loader
    import itcm_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   itcm_ram_we,
    output logic [ITCM_RAM_AW-1:0] itcm_ram_addr,
    output logic [ITCM_RAM_DW-1:0] itcm_ram_din,
    output logic [ITCM_RAM_MW-1:0] itcm_ram_wem,
    input  logic [ITCM_RAM_DW-1:0] itcm_ram_dout,
    output logic                   core_rst_n,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code
);

    logic [2:0]             state_q, state_d;
    logic [2:0]             hcnt_q, hcnt_d;
    logic [31:0]            base_q, base_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            k_q, k_d;
    logic [16:0]            vcnt_q, vcnt_d;
    logic [7:0]             sum_q, sum_d;
    logic [ITCM_RAM_DW-1:0] wsig_q, wsig_d;
    logic [ITCM_RAM_DW-1:0] rsig_q, rsig_d;
    logic                   we_q, we_d;
    logic [ITCM_RAM_AW-1:0] addr_q, addr_d;
    logic [ITCM_RAM_DW-1:0] din_q, din_d;
    logic [ITCM_RAM_MW-1:0] wem_q, wem_d;
    logic                   crst_q, crst_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [1:0]             ecode_q, ecode_d;

    logic                   acc;
    logic [7:0]             sum_add;
    logic [15:0]            n_last;
    logic [15:0]            k_inc;
    logic [16:0]            vj;
    logic [ITCM_RAM_AW-1:0] wr_addr;
    logic [ITCM_RAM_AW-1:0] rd_addr;
    logic [ITCM_RAM_DW-1:0] rsig_nx;
    logic                   wa_valid;
    logic [ITCM_RAM_DW-1:0] wa_word;

    assign in_ready = (state_q != LDR_VERIFY);
    assign acc      = in_valid && in_ready;
    assign sum_add  = sum_q + in_data;
    assign n_last   = {in_data, cnt_q[15:8]};
    assign k_inc    = k_q + 16'd1;
    assign vj       = vcnt_q + 17'd1;
    assign wr_addr  = base_q[ITCM_RAM_AW-1:0] + k_q[ITCM_RAM_AW-1:0];
    assign rd_addr  = base_q[ITCM_RAM_AW-1:0] + vj[ITCM_RAM_AW-1:0];
    assign rsig_nx  = rsig_q ^ ((vj >= 17'd2) ? itcm_ram_dout : '0);

    ldr_word_asm u_word_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (acc && (state_q == LDR_IDLE) && (in_data == LDR_SYNC)),
        .byte_valid_i (acc && (state_q == LDR_DATA)),
        .byte_i       (in_data),
        .word_valid_o (wa_valid),
        .word_o       (wa_word)
    );

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        vcnt_d  = vcnt_q;
        sum_d   = sum_q;
        wsig_d  = wsig_q;
        rsig_d  = rsig_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        wem_d   = '0;
        crst_d  = crst_q;
        done_d  = done_q;
        err_d   = err_q;
        ecode_d = ecode_q;

        case (state_q)
            LDR_IDLE: begin
                if (acc && (in_data == LDR_SYNC)) begin
                    state_d = LDR_HDR;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    ecode_d = '0;
                    crst_d  = 1'b0;
                    sum_d   = '0;
                    hcnt_d  = '0;
                    k_d     = '0;
                    wsig_d  = '0;
                end
            end
            LDR_HDR: begin
                if (acc) begin
                    sum_d  = sum_add;
                    hcnt_d = hcnt_q + 3'd1;
                    if (hcnt_q < 3'd4) begin
                        base_d = {in_data, base_q[31:8]};
                    end else begin
                        cnt_d = n_last;
                    end
                    if (hcnt_q == 3'd5) begin
                        if (!range_ok(base_q, n_last)) begin
                            err_d   = 1'b1;
                            ecode_d = LDR_ERR_RANGE;
                            state_d = LDR_IDLE;
                        end else if (n_last == 16'd0) begin
                            state_d = LDR_CSUM;
                        end else begin
                            state_d = LDR_DATA;
                        end
                    end
                end
            end
            LDR_DATA: begin
                if (acc) begin
                    sum_d = sum_add;
                end
                if (wa_valid) begin
                    we_d   = 1'b1;
                    wem_d  = '1;
                    addr_d = wr_addr;
                    din_d  = wa_word;
                    wsig_d = wsig_q ^ wa_word;
                    k_d    = k_inc;
                    if (k_inc == cnt_q) begin
                        state_d = LDR_CSUM;
                    end
                end
            end
            LDR_CSUM: begin
                if (acc) begin
                    if (sum_add != 8'd0) begin
                        err_d   = 1'b1;
                        ecode_d = LDR_ERR_CSUM;
                        state_d = LDR_IDLE;
                    end else begin
                        // First readback address goes out on the CSUM edge so
                        // VERIFY spans exactly N+1 cycles.
                        state_d = LDR_VERIFY;
                        vcnt_d  = '0;
                        rsig_d  = '0;
                        if (cnt_q != 16'd0) begin
                            addr_d = base_q[ITCM_RAM_AW-1:0];
                        end
                    end
                end
            end
            LDR_VERIFY: begin
                vcnt_d = vj;
                rsig_d = rsig_nx;
                if (vj < {1'b0, cnt_q}) begin
                    addr_d = rd_addr;
                end
                if (vj > {1'b0, cnt_q}) begin
                    state_d = LDR_IDLE;
                    if (rsig_nx == wsig_q) begin
                        done_d = 1'b1;
                        crst_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        ecode_d = LDR_ERR_VERIFY;
                    end
                end
            end
            default: state_d = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LDR_IDLE;
            hcnt_q  <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            vcnt_q  <= '0;
            sum_q   <= '0;
            wsig_q  <= '0;
            rsig_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            wem_q   <= '0;
            crst_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ecode_q <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            vcnt_q  <= vcnt_d;
            sum_q   <= sum_d;
            wsig_q  <= wsig_d;
            rsig_q  <= rsig_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wem_q   <= wem_d;
            crst_q  <= crst_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ecode_q <= ecode_d;
        end
    end

    assign itcm_ram_we   = we_q;
    assign itcm_ram_addr = addr_q;
    assign itcm_ram_din  = din_q;
    assign itcm_ram_wem  = wem_q;
    assign core_rst_n    = crst_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = ecode_q;

endmodule

// File: tb/tb_itcm_loader.sv
// Scoreboard bench for itcm_loader: directed frames drive the byte stream,
// a monitor checks RAM writes and status events against queued expectations.
module tb_itcm_loader;
    import itcm_loader_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic [7:0]             in_data = 8'h00;
    logic                   in_ready;
    logic                   itcm_ram_we;
    logic [ITCM_RAM_AW-1:0] itcm_ram_addr;
    logic [31:0]            itcm_ram_din;
    logic [3:0]             itcm_ram_wem;
    logic [31:0]            itcm_ram_dout = '0;
    logic                   core_rst_n;
    logic                   done;
    logic                   err;
    logic [1:0]             err_code;

    itcm_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .itcm_ram_we   (itcm_ram_we),
        .itcm_ram_addr (itcm_ram_addr),
        .itcm_ram_din  (itcm_ram_din),
        .itcm_ram_wem  (itcm_ram_wem),
        .itcm_ram_dout (itcm_ram_dout),
        .core_rst_n    (core_rst_n),
        .done          (done),
        .err           (err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ITCM_RAM_AW-1:0] addr;
        logic [31:0]            din;
    } wr_t;

    typedef struct packed {
        logic       done;
        logic       err;
        logic [1:0] code;
        logic       crst;
    } st_t;

    wr_t        wq[$];
    st_t        sq[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] fsum;
    logic [31:0] words_buf [0:63];
    logic [31:0] mem     [0:(1<<ITCM_RAM_AW)-1];
    logic [31:0] ref_mem [0:(1<<ITCM_RAM_AW)-1];
    logic        corrupt_en = 1'b0;
    logic [ITCM_RAM_AW-1:0] corrupt_addr = '0;
    logic        done_prev = 1'b0;
    logic        err_prev = 1'b0;

    initial begin
        for (int unsigned i = 0; i < (1 << ITCM_RAM_AW); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
    end

    // RAM model: registered read data one cycle after the address; optional
    // single-address read corruption.
    always @(posedge clk) begin
        if (itcm_ram_we) begin
            for (int unsigned b = 0; b < 4; b++)
                if (itcm_ram_wem[b]) mem[itcm_ram_addr][8*b +: 8] <= itcm_ram_din[8*b +: 8];
        end else begin
            itcm_ram_dout <= mem[itcm_ram_addr] ^
                ((corrupt_en && itcm_ram_addr == corrupt_addr) ? 32'h1 : 32'h0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (itcm_ram_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h din %h expected none",
                             itcm_ram_addr, itcm_ram_din);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", 32'(itcm_ram_addr), 32'(w.addr));
                    chk("wr_din", itcm_ram_din, w.din);
                    chk("wr_wem", 32'(itcm_ram_wem), 32'hF);
                end
            end
            if ((done && !done_prev) || (err && !err_prev)) begin
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_status: got done %b err %b code %0d expected none",
                             done, err, err_code);
                end else begin
                    st_t s;
                    s = sq.pop_front();
                    chk("st_done", 32'(done), 32'(s.done));
                    chk("st_err", 32'(err), 32'(s.err));
                    chk("st_code", 32'(err_code), 32'(s.code));
                    chk("st_core_rst_n", 32'(core_rst_n), 32'(s.crst));
                end
            end
        end
        done_prev = done;
        err_prev  = err;
    end

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned t;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        fsum     = fsum + b;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready 0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned maxgap);
        for (int unsigned i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], $urandom_range(maxgap, 0));
    endtask

    task automatic push_writes(input logic [31:0] base, input int unsigned n);
        logic [31:0] a;
        for (int unsigned i = 0; i < n; i++) begin
            a = base + i;
            wq.push_back('{addr: a[ITCM_RAM_AW-1:0], din: words_buf[i]});
            ref_mem[a[ITCM_RAM_AW-1:0]] = words_buf[i];
        end
    endtask

    task automatic send_frame(input logic [31:0] base, input int unsigned n,
                              input logic [7:0] csum_xor, input int unsigned maxgap);
        logic [15:0] n16;
        logic [7:0]  cs;
        n16 = 16'(n);
        send_byte(LDR_SYNC, 0);
        fsum = 8'h00;
        send_word(base, maxgap);
        send_byte(n16[7:0], 0);
        send_byte(n16[15:8], 0);
        for (int unsigned i = 0; i < n; i++) send_word(words_buf[i], maxgap);
        cs = (8'h00 - fsum) ^ csum_xor;
        send_byte(cs, 0);
    endtask

    logic [7:0] f1 [0:10];
    logic [7:0] f3 [0:6];

    initial begin
        f1 = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
               8'hEF, 8'hBE, 8'hAD, 8'hDE};
        f3 = '{8'hA5, 8'hFF, 8'h03, 8'h00, 8'h00, 8'h02, 8'h00};

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_we", 32'(itcm_ram_we), 32'd0);
        chk("rst_addr", 32'(itcm_ram_addr), 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-word frame with hand-computed checksum 0xB7
        wq.push_back('{addr: 10'h010, din: 32'hDEADBEEF});
        sq.push_back('{done: 1'b1, err: 1'b0, code: 2'd0, crst: 1'b1});
        for (int unsigned i = 0; i < 11; i++) send_byte(f1[i], 0);
        send_byte(8'hB7, 0);
        chk("t1_read_addr", 32'(itcm_ram_addr), 32'h10);
        chk("t1_read_we", 32'(itcm_ram_we), 32'd0);
        chk("t1_verify_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t1_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_core_rst_n", 32'(core_rst_n), 32'd1);
        repeat (2) @(negedge clk);

        // Same frame, bad checksum 0xB6
        wq.push_back('{addr: 10'h010, din: 32'hDEADBEEF});
        sq.push_back('{done: 1'b0, err: 1'b1, code: LDR_ERR_CSUM, crst: 1'b0});
        for (int unsigned i = 0; i < 11; i++) send_byte(f1[i], 0);
        send_byte(8'hB6, 0);
        chk("t2_no_verify", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("t2_err", 32'(err), 32'd1);
        chk("t2_code", 32'(err_code), 32'd2);
        chk("t2_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("t2_done", 32'(done), 32'd0);

        // Range error: BASE = 2^AW-1, N = 2
        sq.push_back('{done: 1'b0, err: 1'b1, code: LDR_ERR_RANGE, crst: 1'b0});
        for (int unsigned i = 0; i < 7; i++) send_byte(f3[i], 0);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_code", 32'(err_code), 32'd1);
        for (int unsigned i = 0; i < 9; i++) send_byte(8'(8'h11 * (i + 1)), 0);
        words_buf[0] = 32'h11223344;
        words_buf[1] = 32'h55667788;
        push_writes(32'h20, 2);
        sq.push_back('{done: 1'b1, err: 1'b0, code: 2'd0, crst: 1'b1});
        send_frame(32'h20, 2, 8'h00, 0);
        repeat (6) @(negedge clk);
        chk("t3_reload_done", 32'(done), 32'd1);
        chk("t3_mem1", mem[10'h021], 32'h55667788);

        // Verify failure: read of word 1 corrupted
        words_buf[0] = 32'hA5A5A5A5;
        words_buf[1] = 32'h01234567;
        words_buf[2] = 32'h89ABCDEF;
        words_buf[3] = 32'hFFFF0000;
        corrupt_en   = 1'b1;
        corrupt_addr = 10'h041;
        push_writes(32'h40, 4);
        sq.push_back('{done: 1'b0, err: 1'b1, code: LDR_ERR_VERIFY, crst: 1'b0});
        send_frame(32'h40, 4, 8'h00, 0);
        repeat (8) @(negedge clk);
        chk("t4_code", 32'(err_code), 32'd3);
        chk("t4_core_rst_n", 32'(core_rst_n), 32'd0);
        corrupt_en = 1'b0;

        // 64-word frame with random input gaps
        for (int unsigned i = 0; i < 64; i++) words_buf[i] = 32'hC0DE0000 + 32'(i * 32'h01010101);
        push_writes(32'h100, 64);
        sq.push_back('{done: 1'b1, err: 1'b0, code: 2'd0, crst: 1'b1});
        send_frame(32'h100, 64, 8'h00, 3);
        repeat (70) @(negedge clk);
        chk("t5_done", 32'(done), 32'd1);
        for (int unsigned i = 0; i < 64; i++) chk("t5_mem", mem[10'h100 + 10'(i)], ref_mem[10'h100 + 10'(i)]);

        // Reset pulse during DATA
        words_buf[0] = 32'hCAFEF00D;
        push_writes(32'h200, 1);
        send_byte(LDR_SYNC, 0);
        send_word(32'h200, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_word(32'hCAFEF00D, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_we", 32'(itcm_ram_we), 32'd0);
        chk("t6_addr", 32'(itcm_ram_addr), 32'd0);
        chk("t6_din", itcm_ram_din, 32'd0);
        chk("t6_wem", 32'(itcm_ram_wem), 32'd0);
        chk("t6_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_code", 32'(err_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_partial", mem[10'h200], 32'hCAFEF00D);
        words_buf[0] = 32'h0BADBEEF;
        words_buf[1] = 32'h600DCAFE;
        push_writes(32'h200, 2);
        sq.push_back('{done: 1'b1, err: 1'b0, code: 2'd0, crst: 1'b1});
        send_frame(32'h200, 2, 8'h00, 0);
        repeat (6) @(negedge clk);
        chk("t6_done_after", 32'(done), 32'd1);
        chk("t6_core_after", 32'(core_rst_n), 32'd1);

        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("sq_empty", 32'(sq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
